// File: rtl/clock_enable_tree.sv
// Single-clock enable tree: prescaler, power-of-two tap chain, square outputs,
// and the CPU clock-mode FSM that gates the datapath advance pulse.
//
//   state        | meaning
//   MODE_MANUAL  | CPU advances once per captured step, released on a base tick
//   MODE_AUTO    | CPU advances on every AUTO_CH tap
//   MODE_TURBO   | CPU advances on every TURBO_CH tap
//   MODE_FAST    | CPU advances on every base tick
module clock_enable_tree #(
  parameter int                  PRE_DIV   = 262144,
  parameter int                  NUM_CH    = 3,
  parameter logic [NUM_CH*5-1:0] CH_SHIFTS = {5'd6, 5'd4, 5'd2},
  parameter int                  AUTO_CH   = 2,
  parameter int                  TURBO_CH  = 1
) (
  input  logic              Board_Clock,
  input  logic              Reset,
  input  logic [1:0]        Mode_Sel,
  input  logic              Step_In,
  input  logic              Halt,
  output logic              Base_Tick,
  output logic [NUM_CH-1:0] Tick,
  output logic [NUM_CH-1:0] Square,
  output logic              CPU_Enable,
  output logic [1:0]        Active_Mode,
  output logic              Step_Pending
);

  function automatic int max_shift();
    int m;
    m = 0;
    for (int k = 0; k < NUM_CH; k++)
      if (int'(CH_SHIFTS[k*5 +: 5]) > m) m = int'(CH_SHIFTS[k*5 +: 5]);
    return m;
  endfunction

  localparam int MAXS = max_shift();
  localparam int PW   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam int QW   = (MAXS > 1) ? MAXS : 1;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_TURBO  = 2'b10,
    MODE_FAST   = 2'b11
  } mode_t;

  logic [PW-1:0]     p;
  logic [QW-1:0]     q;
  logic              bt;
  logic [NUM_CH-1:0] tc;
  logic [2:0]        step_sr;
  logic              step_edge;
  mode_t             mode, mode_nxt;
  logic              en, pend_nxt;

  assign bt          = (p == PW'(PRE_DIV - 1));
  assign step_edge   = step_sr[1] & ~step_sr[2];
  assign Active_Mode = mode;

  // A tap fires when the low CH_SHIFTS[k] bits of q are all ones on a base tick.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam int            SH   = int'(CH_SHIFTS[k*5 +: 5]);
    localparam logic [QW-1:0] MASK = QW'((64'd1 << SH) - 64'd1);
    assign tc[k] = bt & ((q & MASK) == MASK);
  end

  always_ff @(posedge Board_Clock) begin
    if (Reset) mode <= MODE_MANUAL;
    else       mode <= mode_nxt;
  end

  always_comb begin
    mode_nxt = mode;
    en       = 1'b0;
    pend_nxt = Step_Pending;
    if (bt) mode_nxt = mode_t'(Mode_Sel);
    case (mode)
      MODE_MANUAL: en = bt & Step_Pending;
      MODE_AUTO:   en = tc[AUTO_CH];
      MODE_TURBO:  en = tc[TURBO_CH];
      MODE_FAST:   en = bt;
      default:     en = 1'b0;
    endcase
    // A queued step never survives a switch away from MANUAL.
    if (mode != MODE_MANUAL || mode_nxt != MODE_MANUAL) pend_nxt = 1'b0;
    else if (Step_Pending)                             pend_nxt = ~bt;
    else                                               pend_nxt = step_edge;
  end

  always_ff @(posedge Board_Clock) begin
    if (Reset) begin
      p            <= '0;
      q            <= '0;
      step_sr      <= '0;
      Base_Tick    <= 1'b0;
      Tick         <= '0;
      Square       <= '0;
      CPU_Enable   <= 1'b0;
      Step_Pending <= 1'b0;
    end else begin
      p            <= bt ? '0 : p + PW'(1);
      if (bt) q    <= q + QW'(1);
      step_sr      <= {step_sr[1:0], Step_In};
      Base_Tick    <= bt;
      Tick         <= tc;
      Square       <= Square ^ tc;
      CPU_Enable   <= ~Halt & en;
      Step_Pending <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_clock_enable_tree.sv
// Bench for clock_enable_tree: two instances (PRE_DIV=4 and PRE_DIV=1) compared every
// cycle against a cycle-count model, plus literal checks of key event cycles.
module tb_clock_enable_tree;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode_sel = 2'b00;
  logic       step_in = 1'b0;
  logic       halt = 1'b0;

  logic       base0, cpu0, pend0, base1, cpu1, pend1;
  logic [2:0] tick0, sq0, tick1, sq1;
  logic [1:0] mode0, mode1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_enable_tree #(.PRE_DIV(4), .NUM_CH(3), .CH_SHIFTS({5'd6, 5'd4, 5'd2}),
                      .AUTO_CH(2), .TURBO_CH(1)) dut0 (
    .Board_Clock(clk), .Reset(rst), .Mode_Sel(mode_sel), .Step_In(step_in), .Halt(halt),
    .Base_Tick(base0), .Tick(tick0), .Square(sq0), .CPU_Enable(cpu0),
    .Active_Mode(mode0), .Step_Pending(pend0));

  clock_enable_tree #(.PRE_DIV(1), .NUM_CH(3), .CH_SHIFTS({5'd2, 5'd1, 5'd0}),
                      .AUTO_CH(2), .TURBO_CH(1)) dut1 (
    .Board_Clock(clk), .Reset(rst), .Mode_Sel(mode_sel), .Step_In(step_in), .Halt(halt),
    .Base_Tick(base1), .Tick(tick1), .Square(sq1), .CPU_Enable(cpu1),
    .Active_Mode(mode1), .Step_Pending(pend1));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: n = edges since reset release; taps are pure divisibility of n.
  int        n = 0;
  bit        valid = 0;
  bit        s1 = 0, s2 = 0, s3 = 0;
  int        m_mode[2];
  bit        m_pend[2];
  bit        m_cpu[2];

  function automatic int pre_of(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int shf(int d, int k);
    if (d == 0) return (k == 0) ? 2 : (k == 1) ? 4 : 6;
    return k;
  endfunction

  function automatic int period(int d, int k);
    return pre_of(d) << shf(d, k);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      valid = 1;
      n = 0;
      s1 = 0; s2 = 0; s3 = 0;
      for (int d = 0; d < 2; d++) begin
        m_mode[d] = 0; m_pend[d] = 0; m_cpu[d] = 0;
      end
    end else if (valid) begin
      for (int d = 0; d < 2; d++) begin
        bit bt, en, edge_seen;
        int nxt_mode;
        bit tcs[3];
        bt = ((n + 1) % pre_of(d)) == 0;
        for (int k = 0; k < 3; k++) tcs[k] = ((n + 1) % period(d, k)) == 0;
        edge_seen = s2 && !s3;
        case (m_mode[d])
          0: en = bt && m_pend[d];
          1: en = tcs[2];
          2: en = tcs[1];
          default: en = bt;
        endcase
        m_cpu[d] = en && !halt;
        nxt_mode = bt ? int'(mode_sel) : m_mode[d];
        if (m_mode[d] != 0 || nxt_mode != 0) m_pend[d] = 0;
        else if (m_pend[d]) m_pend[d] = !bt;
        else m_pend[d] = edge_seen;
        m_mode[d] = nxt_mode;
      end
      s3 = s2; s2 = s1; s1 = step_in;
      n++;
    end
  end

  task automatic compare(input int d, input logic b, input logic [2:0] t, input logic [2:0] s,
                         input logic c, input logic [1:0] m, input logic p);
    logic [2:0] et, es;
    for (int k = 0; k < 3; k++) begin
      et[k] = (n > 0) && (n % period(d, k) == 0);
      es[k] = ((n / period(d, k)) % 2) == 1;
    end
    check($sformatf("d%0d_base", d), b, (n > 0) && (n % pre_of(d) == 0));
    check($sformatf("d%0d_tick", d), t, et);
    check($sformatf("d%0d_square", d), s, es);
    check($sformatf("d%0d_cpu", d), c, m_cpu[d]);
    check($sformatf("d%0d_mode", d), m, m_mode[d]);
    check($sformatf("d%0d_pending", d), p, m_pend[d]);
  endtask

  always @(negedge clk) begin
    if (valid) begin
      compare(0, base0, tick0, sq0, cpu0, mode0, pend0);
      compare(1, base1, tick1, sq1, cpu1, mode1, pend1);
    end
  end

  task automatic step_cycles(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int cnt;
    step_cycles(3);
    check("rst_base", base0, 0);
    check("rst_tick", tick0, 0);
    check("rst_square", sq0, 0);
    check("rst_cpu", cpu0, 0);
    check("rst_mode", mode0, 0);
    check("rst_pending", pend0, 0);
    rst = 1'b0;

    // Tap timing, AUTO switch, then the same with Halt held.
    for (int c = 1; c <= 900; c++) begin
      step_cycles(1);
      if (c == 3)   check("pin_base_c3", base0, 0);
      if (c == 4)   check("pin_base_c4", base0, 1);
      if (c == 1)   check("pin_d1_tick_c1", tick1, 3'b001);
      if (c == 2)   check("pin_d1_tick_c2", tick1, 3'b011);
      if (c == 4)   check("pin_d1_tick_c4", tick1, 3'b111);
      if (c == 16)  check("pin_tick_c16", tick0, 3'b001);
      if (c == 16)  check("pin_sq0_c16", sq0[0], 1);
      if (c == 32)  check("pin_sq0_c32", sq0[0], 0);
      if (c == 64)  check("pin_tick_c64", tick0, 3'b011);
      if (c == 11)  check("pin_mode_c11", mode0, 0);
      if (c == 12)  check("pin_mode_c12", mode0, 1);
      if (c == 255) check("pin_cpu_c255", cpu0, 0);
      if (c == 256) check("pin_cpu_c256", cpu0, 1);
      if (c == 256) check("pin_tick_c256", tick0, 3'b111);
      if (c == 512) check("pin_cpu_c512", cpu0, 1);
      if (c == 768) check("pin_halt_cpu_c768", cpu0, 0);
      if (c == 768) check("pin_halt_tick_c768", tick0, 3'b111);
      if (c == 9)   mode_sel = 2'b01;
      if (c == 600) halt = 1'b1;
    end

    // Mid-run reset, manual steps, then a switch to FAST with a step queued.
    mode_sel = 2'b00; halt = 1'b0; step_in = 1'b0;
    rst = 1'b1;
    step_cycles(1);
    check("mid_rst_base", base0, 0);
    check("mid_rst_tick", tick0, 0);
    check("mid_rst_square", sq0, 0);
    check("mid_rst_mode", mode0, 0);
    rst = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      step_cycles(1);
      if (c >= 5 && c <= 20 && cpu0) cnt++;
      if (c == 3)  check("resume_base_c3", base0, 0);
      if (c == 4)  check("resume_base_c4", base0, 1);
      if (c == 5)  check("pin_pend_c5", pend0, 1);
      if (c == 7)  check("pin_pend_c7", pend0, 1);
      if (c == 8)  check("pin_step_cpu_c8", cpu0, 1);
      if (c == 8)  check("pin_pend_c8", pend0, 0);
      if (c == 26) check("pin_pend_c26", pend0, 1);
      if (c == 28) check("pin_fast_mode_c28", mode0, 3);
      if (c == 28) check("pin_fast_pend_c28", pend0, 0);
      if (c == 28) check("pin_fast_cpu_c28", cpu0, 1);
      if (c == 29) check("pin_fast_cpu_c29", cpu0, 0);
      if (c == 32) check("pin_fast_cpu_c32", cpu0, 1);
      step_in = (c == 2 || c == 4 || c == 22);
      if (c == 25) mode_sel = 2'b11;
    end
    check("manual_one_pulse", cnt, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 15000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 15) == 0) mode_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) step_in = ~step_in;
      if ($urandom_range(0, 7) == 0) halt = ~halt;
      step_cycles(1);
    end
    rst = 1'b0;
    step_cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
